// File: rtl/eth_mac_gmii_tx.sv
// GMII transmit path of the L2 MAC: Avalon-ST bytes in, preamble, SFD,
// data, zero pad, CRC-32 FCS and inter-frame gap out on GMII.
module eth_mac_gmii_tx #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_FRAME    = 60,
   parameter int IFG_CYCLES   = 12
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       S_avalonST_valid,
   input  logic [7:0] S_avalonST_data,
   input  logic       S_avalonST_sop,
   input  logic       S_avalonST_eop,
   input  logic       S_avalonST_error,
   output logic       S_avalonST_ready,
   output logic [7:0] ENET_TX_DATA,
   output logic       ENET_TX_DV,
   output logic       ENET_TX_ER
);

   typedef enum logic [3:0] {
      IDLE, PREAMBLE, SFD, DATA, ABORT, DROP, PAD, FCS, IFG
   } state_t;

   localparam logic [10:0] PRE_CNT  = 11'(PREAMBLE_LEN - 1);
   localparam logic [10:0] IFG_FULL = 11'(IFG_CYCLES - 1);
   localparam logic [10:0] IFG_TAIL = 11'((IFG_CYCLES > 1) ? IFG_CYCLES - 2 : 0);
   // The IDLE cycle is the last gap cycle after a frame, so the tail is one short.
   localparam state_t GAP_ST = (IFG_CYCLES > 1) ? IFG : IDLE;

   state_t      state;
   logic [10:0] cnt;
   logic [10:0] bcnt;
   logic [31:0] crc;
   logic [7:0]  hold_data;
   logic        hold_eop;
   logic        hold_err;
   logic        last;
   logic        accept;
   logic        pad_more;
   logic [10:0] bcnt_inc;

   function automatic logic [31:0] crc_step(input logic [31:0] c,
                                            input logic [7:0]  d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   assign S_avalonST_ready = (state == IDLE) || (state == DROP) ||
                             ((state == DATA) && !last);
   assign accept   = S_avalonST_valid && S_avalonST_ready;
   assign bcnt_inc = (bcnt == 11'h7FF) ? bcnt : bcnt + 11'd1;
   assign pad_more = int'(bcnt) < MIN_FRAME;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state        <= IFG;
         cnt          <= IFG_FULL;
         bcnt         <= '0;
         crc          <= '1;
         hold_data    <= '0;
         hold_eop     <= 1'b0;
         hold_err     <= 1'b0;
         last         <= 1'b0;
         ENET_TX_DATA <= '0;
         ENET_TX_DV   <= 1'b0;
         ENET_TX_ER   <= 1'b0;
      end else begin
         ENET_TX_DATA <= 8'h00;
         ENET_TX_DV   <= 1'b0;
         ENET_TX_ER   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept && S_avalonST_sop) begin
                  hold_data    <= S_avalonST_data;
                  hold_eop     <= S_avalonST_eop;
                  hold_err     <= S_avalonST_error;
                  state        <= PREAMBLE;
                  cnt          <= PRE_CNT;
                  ENET_TX_DV   <= 1'b1;
                  ENET_TX_DATA <= 8'h55;
               end
            end
            PREAMBLE: begin
               ENET_TX_DV <= 1'b1;
               if (cnt == 11'd0) begin
                  state        <= SFD;
                  ENET_TX_DATA <= 8'hD5;
                  bcnt         <= '0;
                  crc          <= '1;
               end else begin
                  cnt          <= cnt - 11'd1;
                  ENET_TX_DATA <= 8'h55;
               end
            end
            SFD: begin
               state        <= DATA;
               ENET_TX_DV   <= 1'b1;
               ENET_TX_DATA <= hold_data;
               ENET_TX_ER   <= hold_err;
               last         <= hold_eop;
               bcnt         <= bcnt_inc;
               crc          <= crc_step(crc, hold_data);
            end
            DATA, PAD: begin
               if ((state == PAD) || last) begin
                  ENET_TX_DV <= 1'b1;
                  if (pad_more) begin
                     state <= PAD;
                     bcnt  <= bcnt_inc;
                     crc   <= crc_step(crc, 8'h00);
                  end else begin
                     state        <= FCS;
                     cnt          <= 11'd3;
                     ENET_TX_DATA <= ~crc[7:0];
                     crc          <= {8'h00, crc[31:8]};
                  end
               end else if (S_avalonST_valid) begin
                  ENET_TX_DV   <= 1'b1;
                  ENET_TX_DATA <= S_avalonST_data;
                  ENET_TX_ER   <= S_avalonST_error;
                  last         <= S_avalonST_eop;
                  bcnt         <= bcnt_inc;
                  crc          <= crc_step(crc, S_avalonST_data);
               end else begin
                  state      <= ABORT;
                  ENET_TX_DV <= 1'b1;
                  ENET_TX_ER <= 1'b1;
               end
            end
            ABORT: state <= DROP;
            DROP: begin
               if (accept && S_avalonST_eop) begin
                  state <= GAP_ST;
                  cnt   <= IFG_TAIL;
               end
            end
            FCS: begin
               if (cnt == 11'd0) begin
                  state <= GAP_ST;
                  cnt   <= IFG_TAIL;
               end else begin
                  cnt          <= cnt - 11'd1;
                  ENET_TX_DV   <= 1'b1;
                  ENET_TX_DATA <= ~crc[7:0];
                  crc          <= {8'h00, crc[31:8]};
               end
            end
            IFG: begin
               if (cnt == 11'd0) state <= IDLE;
               else cnt <= cnt - 11'd1;
            end
            default: state <= IFG;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_mac_gmii_tx.sv
// Bench for eth_mac_gmii_tx: random frames against a queue model of the
// expected GMII wire bursts, plus literal anchors for the model itself.
module tb_eth_mac_gmii_tx;

   localparam int IFG  = 12;
   localparam int MINF = 60;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;
   logic       vld = 1'b0;
   logic       sop = 1'b0;
   logic       eop = 1'b0;
   logic       err = 1'b0;
   logic [7:0] dat = 8'h00;
   logic       vld0, vld1, rdy0, rdy1, rdy;
   logic       dv0, er0, dv1, er1;
   logic [7:0] txd0, txd1;

   always #4 clk = ~clk;

   assign vld0 = vld & ~sel;
   assign vld1 = vld & sel;
   assign rdy  = sel ? rdy1 : rdy0;

   eth_mac_gmii_tx u0 (
      .Clk(clk), .Rst_n(rst_n),
      .S_avalonST_valid(vld0), .S_avalonST_data(dat),
      .S_avalonST_sop(sop), .S_avalonST_eop(eop),
      .S_avalonST_error(err), .S_avalonST_ready(rdy0),
      .ENET_TX_DATA(txd0), .ENET_TX_DV(dv0), .ENET_TX_ER(er0)
   );

   eth_mac_gmii_tx #(.MIN_FRAME(0)) u1 (
      .Clk(clk), .Rst_n(rst_n),
      .S_avalonST_valid(vld1), .S_avalonST_data(dat),
      .S_avalonST_sop(sop), .S_avalonST_eop(eop),
      .S_avalonST_error(err), .S_avalonST_ready(rdy1),
      .ENET_TX_DATA(txd1), .ENET_TX_DV(dv1), .ENET_TX_ER(er1)
   );

   int errs = 0;
   int checks = 0;

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      checks++;
      if (!ok) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   // Expected wire bytes while DV=1: {end_of_burst, er, data}
   logic [9:0] eq[$];
   logic [7:0] fb[2048];
   logic       fe[2048];

   task automatic model_frame(input int len, input int u);
      logic [31:0] c;
      logic [7:0]  b;
      int          n;
      for (int i = 0; i < 7; i++) eq.push_back({2'b00, 8'h55});
      eq.push_back(10'h0D5);
      if (u >= 0) begin
         for (int i = 0; i < u; i++) eq.push_back({1'b0, fe[i], fb[i]});
         eq.push_back({2'b11, 8'h00});
      end else begin
         c = '1;
         n = (len < MINF) ? MINF : len;
         for (int i = 0; i < n; i++) begin
            b = (i < len) ? fb[i] : 8'h00;
            eq.push_back({1'b0, (i < len) && fe[i], b});
            c = crc_upd(c, b);
         end
         c = ~c;
         for (int i = 0; i < 4; i++) eq.push_back({i == 3, 1'b0, c[8*i +: 8]});
      end
   endtask

   // Called just after a falling edge; returns just after the accepting edge.
   task automatic put(input logic [7:0] b, input bit s, input bit e, input bit r);
      int n;
      n = 0;
      vld = 1'b1; dat = b; sop = s; eop = e; err = r;
      while (!rdy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(rdy, "ready_timeout", n, 0);
      if (rdy) @(negedge clk);
      vld = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0;
   endtask

   task automatic frame(input int len, input int u, input int stop, input int err_at);
      for (int i = 0; i < len; i++) begin
         fb[i] = 8'($urandom);
         fe[i] = (i == err_at);
      end
      model_frame(len, u);
      for (int i = 0; i < stop; i++) begin
         if (u >= 0 && i == u) @(negedge clk);
         put(fb[i], i == 0, i == len - 1, fe[i]);
      end
   endtask

   bit in_burst = 1'b0;
   int gap = 0, last_gap = 0, blen = 0, ercnt = 0, done_len = 0, done_er = 0;

   always @(negedge clk) begin
      logic [9:0] e;
      if (!rst_n) begin
         chk(!dv0 && !er0 && txd0 == 8'h00, "reset_out", int'({dv0, er0, txd0}), 0);
         eq.delete();
         in_burst = 1'b0;
         gap = 0;
      end else if (dv0) begin
         if (!in_burst) begin
            last_gap = gap;
            chk(gap >= IFG, "ifg_min", gap, IFG);
            in_burst = 1'b1;
            blen = 0;
            ercnt = 0;
         end
         blen++;
         if (er0) ercnt++;
         chk(eq.size() != 0, "unexpected_dv", int'(txd0), 0);
         if (eq.size() != 0) begin
            e = eq.pop_front();
            chk({er0, txd0} == e[8:0], "wire_byte", int'({er0, txd0}), int'(e[8:0]));
            if (e[9]) begin
               in_burst = 1'b0;
               gap = 0;
               done_len = blen;
               done_er = ercnt;
            end
         end else begin
            in_burst = 1'b0;
            gap = 0;
         end
      end else begin
         chk(!er0 && txd0 == 8'h00, "idle_out", int'({er0, txd0}), 0);
         chk(!in_burst, "dv_early_low", blen, 0);
         in_burst = 1'b0;
         gap++;
      end
   end

   logic [8:0] cap1[$];
   int z1 = 0;
   always @(negedge clk) begin
      if (dv1) begin
         cap1.push_back({er1, txd1});
         z1 = 0;
      end else begin
         z1++;
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while ((eq.size() != 0 || in_burst) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk(eq.size() == 0 && !in_burst, "drain", eq.size(), 0);
      repeat (IFG + 2) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [8:0]  exp2[21];
      logic [31:0] c;
      int len, u, ea, k, n;

      // Reset release: ready low for exactly 12 cycles
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         chk(rdy0 == (i >= 12), "reset_ready0", int'(rdy0), int'(i >= 12));
         chk(rdy1 == (i >= 12), "reset_ready1", int'(rdy1), int'(i >= 12));
      end

      // "123456789" with no padding on the second instance
      c = '1;
      for (int i = 0; i < 9; i++) c = crc_upd(c, 8'(8'h31 + i));
      chk(~c == 32'hCBF4_3926, "crc_model", int'(~c), 32'hCBF4_3926);
      for (int i = 0; i < 7; i++) exp2[i] = 9'h055;
      exp2[7] = 9'h0D5;
      for (int i = 0; i < 9; i++) exp2[8 + i] = {1'b0, 8'(8'h31 + i)};
      exp2[17] = 9'h026; exp2[18] = 9'h039;
      exp2[19] = 9'h0F4; exp2[20] = 9'h0CB;
      sel = 1'b1;
      for (int i = 0; i < 9; i++) put(8'(8'h31 + i), i == 0, i == 8, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!rdy1 && n < 300);
      chk(cap1.size() == 21, "t2_len", cap1.size(), 21);
      for (int i = 0; i < 21; i++)
         if (i < cap1.size())
            chk(cap1[i] == exp2[i], "t2_byte", int'(cap1[i]), int'(exp2[i]));
      chk(z1 == IFG, "t2_gap", z1, IFG);
      sel = 1'b0;

      // Short frame padded to 60 bytes
      frame(14, -1, 14, -1);
      drain();
      chk(done_len == 72, "pad_dv_len", done_len, 72);

      // Underrun at byte 20 of 100
      frame(100, 20, 100, -1);
      drain();
      chk(done_len == 29, "underrun_len", done_len, 29);
      chk(done_er == 1, "underrun_er", done_er, 1);

      // Error on byte 5 only
      frame(30, -1, 30, 5);
      drain();
      chk(done_er == 1, "err_count", done_er, 1);
      chk(done_len == 72, "err_len", done_len, 72);

      // Random frames, gaps, junk beats, underruns and errors
      for (int f = 0; f < 24; f++) begin
         len = $urandom_range(130, 1);
         u = -1;
         ea = -1;
         if (len >= 3 && $urandom_range(4, 0) == 0) u = $urandom_range(len - 1, 2);
         if ($urandom_range(3, 0) == 0) ea = $urandom_range(len - 1, 0);
         k = $urandom_range(15, 0);
         repeat (k) begin
            vld = 1'($urandom_range(1, 0));
            dat = 8'($urandom);
            @(negedge clk);
            vld = 1'b0;
         end
         frame(len, u, len, ea);
      end
      drain();

      // Back-to-back 64-byte frames, reset during the second
      frame(64, -1, 64, -1);
      frame(64, -1, 40, -1);
      chk(last_gap == IFG, "b2b_gap", last_gap, IFG);
      @(posedge clk);
      #1;
      chk(dv0 == 1'b1, "midframe_dv", int'(dv0), 1);
      rst_n = 1'b0;
      #1;
      chk(!dv0 && !er0 && txd0 == 8'h00 && !rdy0, "abort_out",
          int'({rdy0, dv0, er0, txd0}), 0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (11) @(negedge clk);
      chk(!rdy0, "rerst_ready_lo", int'(rdy0), 0);
      @(negedge clk);
      chk(rdy0, "rerst_ready_hi", int'(rdy0), 1);
      frame(70, -1, 70, -1);
      drain();
      chk(done_len == 82, "recover_len", done_len, 82);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
